// File: rtl/fan_pkg.sv
// Shared definitions for the fan PWM / tach core.
//   - Default parameter values for widths and filter/stall settings.
//   - Tach filter FSM state type.
//   - Saturating increment helper used by the pulse counter.
package fan_pkg;

  localparam int unsigned DefDutyW    = 8;
  localparam int unsigned DefPrescW   = 16;
  localparam int unsigned DefWinW     = 32;
  localparam int unsigned DefTachW    = 16;
  localparam int unsigned DefFiltCyc  = 4;
  localparam int unsigned DefStallWin = 2;

  // StLow/StHigh hold an accepted level; StChkH/StChkL qualify a candidate change.
  typedef enum logic [1:0] {
    StLow  = 2'd0,
    StChkH = 2'd1,
    StHigh = 2'd2,
    StChkL = 2'd3
  } filt_state_e;

  // Increment that sticks at max_val. Callers zero-extend narrower values and truncate the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/fan_tach_filter.sv
// Tach input conditioning: 2-flop synchronizer followed by a level-qualification FSM.
// A level change is accepted only after the synchronized input holds it for FiltCyc clocks.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset
//   tach_i   raw asynchronous tach input
//   edge_o   one-clock strobe when a high level is accepted (filtered rising edge)
//   level_o  filtered tach level
module fan_tach_filter
  import fan_pkg::*;
#(
  parameter int unsigned FiltCyc = DefFiltCyc  // must be at least 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tach_i,
  output logic edge_o,
  output logic level_o
);

  localparam int unsigned CntW = $clog2(FiltCyc + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FiltCyc - 1);

  logic        sync1_q, sync2_q;
  logic        raw;
  filt_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        edge_q, edge_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= tach_i;
      sync2_q <= sync1_q;
    end
  end

  assign raw = sync2_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StLow;
      cnt_q   <= '0;
      edge_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
    end
  end

  // Next state. cnt_q counts consecutive clocks the candidate level has been seen; entering a
  // check state already counts the first one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = 1'b0;
    unique case (state_q)
      StLow: begin
        if (raw) begin
          state_d = StChkH;
          cnt_d   = CntW'(1);
        end
      end
      StChkH: begin
        if (!raw) begin
          state_d = StLow;
        end else if (cnt_q == CntLast) begin
          state_d = StHigh;
          edge_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (!raw) begin
          state_d = StChkL;
          cnt_d   = CntW'(1);
        end
      end
      StChkL: begin
        if (raw) begin
          state_d = StHigh;
        end else if (cnt_q == CntLast) begin
          state_d = StLow;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StLow;
    endcase
  end

  // Outputs
  always_comb begin
    edge_o  = edge_q;
    level_o = (state_q == StHigh) || (state_q == StChkL);
  end

endmodule

// File: rtl/fan_pwm_tach.sv
// Fan drive and speed-sense core.
//   PWM: prescaled tick drives a DUTY_W-bit period counter; duty is shadowed at period start so
//   register writes never split a period. pwm_out is registered.
//   Tach: filtered rising edges are counted over a window of win_len clocks; each window end
//   publishes the count with a one-clock tach_valid strobe and updates the stall flag.
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   en, force_full        core enable, force drive high
//   duty, prescale        requested duty, tick every prescale+1 clocks
//   win_len               window length in clocks (0 disables measurement)
//   tach_in               asynchronous tach input
//   pwm_out               fan drive
//   tach_count/tach_valid last completed window count and its update strobe
//   stall                 STALL_WIN consecutive empty windows while driving
module fan_pwm_tach
  import fan_pkg::*;
#(
  parameter int unsigned DUTY_W    = DefDutyW,
  parameter int unsigned PRESC_W   = DefPrescW,
  parameter int unsigned WIN_W     = DefWinW,
  parameter int unsigned TACH_W    = DefTachW,  // at most 32
  parameter int unsigned FILT_CYC  = DefFiltCyc,
  parameter int unsigned STALL_WIN = DefStallWin
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               en,
  input  logic               force_full,
  input  logic [DUTY_W-1:0]  duty,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [WIN_W-1:0]   win_len,
  input  logic               tach_in,
  output logic               pwm_out,
  output logic [TACH_W-1:0]  tach_count,
  output logic               tach_valid,
  output logic               stall
);

  localparam logic [DUTY_W-1:0] PwmMax   = {DUTY_W{1'b1}};
  localparam logic [31:0]       PulseMax = 32'({TACH_W{1'b1}});
  localparam int unsigned       ZeroW    = $clog2(STALL_WIN + 1);
  localparam logic [ZeroW-1:0]  ZeroLim  = ZeroW'(STALL_WIN);

  logic               tick;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DUTY_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [DUTY_W-1:0]  duty_sh_q, duty_sh_d;
  logic               pwm_q, pwm_d;

  logic               tach_edge;
  logic               unused_tach_level;
  logic               win_end;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [TACH_W-1:0]  pulse_q, pulse_d, pulse_now;
  logic [TACH_W-1:0]  count_q, count_d;
  logic               valid_q, valid_d;
  logic [ZeroW-1:0]   zero_q, zero_d;
  logic               stall_q, stall_d;

  fan_tach_filter #(
    .FiltCyc (FILT_CYC)
  ) u_filter (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .tach_i  (tach_in),
    .edge_o  (tach_edge),
    .level_o (unused_tach_level)
  );

  // PWM path
  always_comb begin
    // >= rather than == so a prescale lowered below the running count wraps at once.
    tick      = (presc_q >= prescale);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    duty_sh_d = (tick && (pwm_cnt_q == PwmMax)) ? duty : duty_sh_q;
    if (!en) begin
      presc_d   = '0;
      pwm_cnt_d = '0;
      duty_sh_d = '0;
    end
    pwm_d = force_full | (en & (pwm_cnt_q < duty_sh_q));
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      // Reset release is a period start, so the first period already uses the requested duty.
      duty_sh_q <= duty;
      pwm_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_sh_q <= duty_sh_d;
      pwm_q     <= pwm_d;
    end
  end

  // Tach window, pulse count and stall
  always_comb begin
    win_end   = en && (win_len != '0) && (win_q >= win_len - 1'b1);
    // An edge landing on the window's last clock belongs to that window.
    pulse_now = tach_edge ? TACH_W'(sat_inc(32'(pulse_q), PulseMax)) : pulse_q;
    win_d     = win_end ? '0 : win_q + 1'b1;
    pulse_d   = win_end ? '0 : pulse_now;
    count_d   = win_end ? pulse_now : count_q;
    valid_d   = win_end;
    zero_d    = zero_q;
    stall_d   = stall_q;
    if (win_end) begin
      if (pulse_now != '0) begin
        zero_d  = '0;
        stall_d = 1'b0;
      end else if (duty_sh_q == '0) begin
        // Fan not driven: an empty window says nothing about a stall.
        zero_d = '0;
      end else begin
        zero_d = (zero_q >= ZeroLim) ? zero_q : zero_q + 1'b1;
        if (zero_d >= ZeroLim) begin
          stall_d = 1'b1;
        end
      end
    end
    if (!en || (win_len == '0)) begin
      win_d   = '0;
      pulse_d = '0;
    end
    if (!en) begin
      zero_d  = '0;
      stall_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      win_q   <= '0;
      pulse_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      zero_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      stall_q <= stall_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign tach_count = count_q;
  assign tach_valid = valid_q;
  assign stall      = stall_q;

endmodule

// File: tb/tb_fan_pwm_tach.sv
module tb_fan_pwm_tach;

  localparam int unsigned DutyW    = 8;
  localparam int unsigned PrescW   = 16;
  localparam int unsigned WinW     = 32;
  localparam int unsigned TachW    = 4;   // small so saturation is reachable
  localparam int unsigned FiltCyc  = 4;
  localparam int unsigned StallWin = 2;
  localparam int          SatMax   = (1 << TachW) - 1;
  localparam int          MaxN     = 4000;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic              en = 1'b0;
  logic              force_full = 1'b0;
  logic [DutyW-1:0]  duty = '0;
  logic [PrescW-1:0] prescale = '0;
  logic [WinW-1:0]   win_len = '0;
  logic              tach_in = 1'b0;
  logic              pwm_out;
  logic [TachW-1:0]  tach_count;
  logic              tach_valid;
  logic              stall;

  int n_cmp = 0;
  int n_bad = 0;
  bit wave [0:MaxN];

  typedef struct {
    bit en;
    bit ff;
    int duty;
    int exp_pwm;
  } fvec_t;

  fvec_t fv [7];

  fan_pwm_tach #(
    .DUTY_W    (DutyW),
    .PRESC_W   (PrescW),
    .WIN_W     (WinW),
    .TACH_W    (TachW),
    .FILT_CYC  (FiltCyc),
    .STALL_WIN (StallWin)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .en         (en),
    .force_full (force_full),
    .duty       (duty),
    .prescale   (prescale),
    .win_len    (win_len),
    .tach_in    (tach_in),
    .pwm_out    (pwm_out),
    .tach_count (tach_count),
    .tach_valid (tach_valid),
    .stall      (stall)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge ACLK);
    #1;
  endtask

  // Reset for 'cycles' clocks; outputs must be zero after the first reset edge.
  // On return the next posedge is edge 1 after release.
  task automatic do_reset(input int cycles);
    ARESET  = 1'b1;
    tach_in = 1'b0;
    clk1();
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_count", int'(tach_count), 0);
    check("rst_valid", int'(tach_valid), 0);
    check("rst_stall", int'(stall), 0);
    repeat (cycles - 1) clk1();
    ARESET = 1'b0;
  endtask

  // PWM model: edge n sits at period phase ((n-1)/(p+1)) mod 256; drive is high while the
  // phase is below the duty captured when the period began.
  task automatic run_pwm(input int p, input int d0, input int nedges, input int chg_edge,
                         input int d1, input bit rnd);
    int sh;
    int len;
    int exp;
    en         = 1'b1;
    force_full = 1'b0;
    prescale   = PrescW'(p);
    duty       = DutyW'(d0);
    win_len    = '0;
    do_reset(2);
    sh  = d0;
    len = 256 * (p + 1);
    for (int n = 1; n <= nedges; n++) begin
      if (n == chg_edge) duty = DutyW'(d1);
      if (rnd && ($urandom_range(0, 149) == 0)) duty = DutyW'($urandom_range(0, 255));
      exp = (((n - 1) / (p + 1)) % 256 < sh) ? 1 : 0;
      clk1();
      check("pwm", int'(pwm_out), exp);
      if (n % len == 0) sh = int'(duty);
    end
  endtask

  task automatic wave_clear();
    for (int i = 0; i <= MaxN; i++) wave[i] = 1'b0;
  endtask

  task automatic wave_pulse(input int start, input int w);
    for (int i = start; (i < start + w) && (i <= MaxN); i++) wave[i] = 1'b1;
  endtask

  // Tach model: wave[n] is the tach level sampled at edge n. A high run of at least FiltCyc
  // clocks starting at edge s is one pulse, counted by the window containing edge
  // s + 2 + FiltCyc. Windows end every wl edges after reset release.
  task automatic run_tach(input int wl, input int nedges, input bit duty_zero);
    int arr[$];
    int run;
    int last_cnt;
    int zeros;
    int c;
    bit exp_stall;
    run = 0;
    for (int n = 1; n <= nedges; n++) begin
      if (wave[n]) begin
        run++;
        if (run == FiltCyc) arr.push_back((n - FiltCyc + 1) + 2 + FiltCyc);
      end else begin
        run = 0;
      end
    end
    en         = 1'b1;
    force_full = 1'b0;
    prescale   = '0;
    duty       = duty_zero ? DutyW'(0) : DutyW'(128);
    win_len    = WinW'(wl);
    do_reset(2);
    last_cnt  = 0;
    zeros     = 0;
    exp_stall = 1'b0;
    for (int n = 1; n <= nedges; n++) begin
      tach_in = wave[n];
      clk1();
      if (n % wl == 0) begin
        c = 0;
        foreach (arr[i]) if ((arr[i] > n - wl) && (arr[i] <= n)) c++;
        if (c > SatMax) c = SatMax;
        last_cnt = c;
        if (c != 0) begin
          zeros     = 0;
          exp_stall = 1'b0;
        end else if (duty_zero) begin
          zeros = 0;
        end else begin
          zeros++;
          if (zeros >= StallWin) exp_stall = 1'b1;
        end
        check("tach_valid_end", int'(tach_valid), 1);
      end else begin
        check("tach_valid_mid", int'(tach_valid), 0);
      end
      check("tach_count", int'(tach_count), last_cnt);
      check("stall", int'(stall), int'(exp_stall));
    end
    tach_in = 1'b0;
  endtask

  initial begin
    int pos;
    int wl;

    // Constant-level drive table: prescale 3, applied after a reset with duty 0.
    fv[0] = '{en: 1'b1, ff: 1'b0, duty: 0,   exp_pwm: 0};
    fv[1] = '{en: 1'b1, ff: 1'b1, duty: 0,   exp_pwm: 1};
    fv[2] = '{en: 1'b0, ff: 1'b1, duty: 0,   exp_pwm: 1};
    fv[3] = '{en: 1'b0, ff: 1'b0, duty: 0,   exp_pwm: 0};
    fv[4] = '{en: 1'b1, ff: 1'b0, duty: 200, exp_pwm: 0};  // re-enable: shadow is 0 this period
    fv[5] = '{en: 1'b1, ff: 1'b1, duty: 200, exp_pwm: 1};
    fv[6] = '{en: 1'b0, ff: 1'b0, duty: 255, exp_pwm: 0};

    // PWM: duty 64, then 64->192 mid-period; no runt, new duty from the next period.
    run_pwm(0, 64, 600, 100, 192, 1'b0);
    // Boundaries: full-scale duty is never constant high; duty 0 is constant low.
    run_pwm(0, 255, 520, 0, 0, 1'b0);
    run_pwm(1, 0, 520, 0, 0, 1'b0);
    // Randomized duty and prescale.
    for (int t = 0; t < 3; t++) begin
      int p;
      p = int'($urandom_range(0, 2));
      run_pwm(p, int'($urandom_range(0, 255)), 2 * 256 * (p + 1) + 40, 0, 0, 1'b1);
    end

    // Table-driven force_full / en vectors; pwm_out follows one clock later.
    en = 1'b1; force_full = 1'b0; prescale = PrescW'(3); duty = '0; win_len = '0;
    do_reset(2);
    foreach (fv[i]) begin
      en         = fv[i].en;
      force_full = fv[i].ff;
      duty       = DutyW'(fv[i].duty);
      for (int k = 0; k < 8; k++) begin
        clk1();
        check("force_tbl", int'(pwm_out), fv[i].exp_pwm);
      end
    end

    // 3-clock pulses (rejected) alternating with 10-clock pulses, 100-clock spacing.
    wave_clear();
    for (int k = 0; k < 30; k++) wave_pulse(50 + 100 * k, (k % 2 == 0) ? 3 : 10);
    run_tach(1000, 3000, 1'b0);

    // Exactly FILT_CYC and FILT_CYC-1 wide pulses.
    wave_clear();
    for (int k = 0; k < 10; k++) wave_pulse(20 + 40 * k, (k % 2 == 0) ? FiltCyc : FiltCyc - 1);
    run_tach(200, 400, 1'b0);

    // Stall: quiet for two windows, then one pulse clears it.
    wave_clear();
    wave_pulse(1100, 10);
    run_tach(500, 1600, 1'b0);

    // Stall then disable: en=0 clears stall next clock.
    wave_clear();
    run_tach(500, 1000, 1'b0);
    en = 1'b0;
    clk1();
    check("stall_en_off", int'(stall), 0);

    // Undriven fan (duty 0): empty windows never assert stall.
    wave_clear();
    run_tach(200, 800, 1'b1);

    // Mid-window reset with pulses pending; the next run restarts windows from release.
    wave_clear();
    for (int k = 0; k < 6; k++) wave_pulse(30 + 100 * k, 10);
    run_tach(400, 600, 1'b0);
    wave_clear();
    for (int k = 0; k < 7; k++) wave_pulse(60 + 100 * k, 12);
    run_tach(400, 800, 1'b0);

    // Randomized pulse trains, dense enough to saturate some windows.
    for (int t = 0; t < 3; t++) begin
      wave_clear();
      wl  = int'($urandom_range(100, 400));
      pos = 10;
      while (pos < 3 * wl) begin
        int w;
        w = int'($urandom_range(1, 12));
        wave_pulse(pos, w);
        pos += w + ((($urandom_range(0, 9)) == 0) ? int'($urandom_range(150, 300))
                                                  : int'($urandom_range(FiltCyc + 2, 30)));
      end
      run_tach(wl, 3 * wl + 10, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
